// File: rtl/npu_io_pkg.sv
// Shared types and constants for the NPU input stage: mode encodings,
// IEEE-754 single field layout, saturation bounds and the stage-1 decode record.
package npu_io_pkg;

  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_FLOAT = 1'b1;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Stage-1 shift field; larger shifts are clamped, which already flushes any operand.
  localparam int SH_W   = 6;
  localparam int SH_MAX = 2**SH_W - 1;

  function automatic logic signed [63:0] sat_bound(input int w, input logic neg);
    sat_bound = neg ? -(64'sd1 <<< (w - 1)) : (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  typedef struct packed {
    logic            valid;
    logic            mode;
    logic            sign;
    logic            left;
    logic [SH_W-1:0] shift;
    logic            ovf;
    logic            nan;
  } s1_t;

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with level/full/empty.
// Pops on empty are dropped; a push at level 0 is not bypassed to the head.
module npu_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/npu_input_convert_fifo.sv
// NPU input stage: int/float32 -> saturated fixed point, 2-stage pipeline into a
// credit-guarded FWFT FIFO. Define NPU_IN_SAT_COUNT_EN to add the sat_count output.
module npu_input_convert_fifo
  import npu_io_pkg::*;
#(
  parameter int IN_W      = 33,
  parameter int FIX_W     = 16,
  parameter int FRAC_BITS = 7,
  parameter int DEPTH     = 16,
  parameter int SHIFT_W   = 6
) (
  input  logic                   CLK,
  input  logic                   npu_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   conf_en,
  input  logic [FIX_W-1:0]       conf_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIX_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   full,
  output logic                   empty,
`ifdef NPU_IN_SAT_COUNT_EN
  output logic [15:0]            sat_count,
`endif
  output logic                   sat_flag
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int WW = IN_W + FRAC_BITS + 1;
  localparam int KW = SHIFT_W + 10;
  localparam int FP_K_OFS = FP_BIAS + FP_MAN_W - FRAC_BITS;
  localparam logic signed [WW-1:0] FIX_MAX = WW'(sat_bound(FIX_W, 1'b0));
  localparam logic signed [WW-1:0] FIX_MIN = WW'(sat_bound(FIX_W, 1'b1));

  logic                 conf_mode;
  logic [SHIFT_W-1:0]   conf_s;
  logic                 acc;
  logic [LW:0]          credits_used;
  s1_t                  s1_d, s1_q;
  logic [IN_W-1:0]      val_d, val_q;
  logic [KW-1:0]        s_ext, int_sh, fp_j;
  logic signed [KW-1:0] fp_k;
  logic                 int_left;
  logic signed [WW-1:0] val_x, wide;
  logic                 hi, lo, sat_d;
  logic [FIX_W-1:0]     res_d, s2_data;
  logic                 s2_vld, s2_sat;
  logic                 unused_conf;

  function automatic logic [SH_W-1:0] sh_clamp(input logic [KW-1:0] x);
    return (x > KW'(SH_MAX)) ? SH_W'(SH_MAX) : x[SH_W-1:0];
  endfunction

  // Credits come only from registered state, so in_ready never sees out_ready.
  assign credits_used = (LW+1)'(fifo_level) + (LW+1)'(s1_q.valid) + (LW+1)'(s2_vld);
  assign in_ready     = credits_used < (LW+1)'(DEPTH);
  assign acc          = in_valid && in_ready;
  assign unused_conf  = ^conf_data[FIX_W-2:SHIFT_W];

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      conf_mode <= MODE_INT;
      conf_s    <= '0;
    end else if (conf_en) begin
      conf_mode <= conf_data[FIX_W-1];
      conf_s    <= conf_data[SHIFT_W-1:0];
    end
  end

  // Decode. Float magnitude is M * 2^k, k = e + S - (bias + mant_w - frac).
  assign s_ext    = KW'(conf_s);
  assign int_left = s_ext <= KW'(FRAC_BITS);
  assign int_sh   = int_left ? KW'(FRAC_BITS) - s_ext : s_ext - KW'(FRAC_BITS);
  assign fp_k     = $signed(KW'(in_data[30:23])) + $signed(s_ext) - $signed(KW'(FP_K_OFS));
  assign fp_j     = -fp_k;

  always_comb begin
    s1_d       = '0;
    val_d      = '0;
    s1_d.valid = acc;
    s1_d.mode  = conf_mode;
    if (conf_mode == MODE_INT) begin
      s1_d.sign  = in_data[IN_W-1];
      s1_d.left  = int_left;
      s1_d.shift = sh_clamp(int_sh);
      val_d      = in_data;
    end else begin
      s1_d.sign = in_data[31];
      if (&in_data[30:23]) begin
        s1_d.nan = |in_data[22:0];
        s1_d.ovf = ~|in_data[22:0];
      end else if (|in_data[30:23]) begin
        // Any right shift short of this leaves at least 2^FIX_W: certain overflow.
        s1_d.ovf   = fp_k >= $signed(KW'(FIX_W - FP_MAN_W));
        s1_d.shift = sh_clamp(fp_j);
        val_d      = IN_W'({1'b1, in_data[22:0]});
      end
    end
  end

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      s1_q  <= '0;
      val_q <= '0;
    end else begin
      s1_q  <= s1_d;
      val_q <= val_d;
    end
  end

  // Int: arithmetic shift (floor on right). Float: shift magnitude then sign -> trunc to zero.
  assign val_x = (s1_q.mode == MODE_INT) ? {{(WW-IN_W){val_q[IN_W-1]}}, val_q}
                                         : {{(WW-IN_W){1'b0}}, val_q};

  always_comb begin
    wide = '0;
    if (s1_q.mode == MODE_INT) begin
      wide = s1_q.left ? (val_x <<< s1_q.shift) : (val_x >>> s1_q.shift);
    end else begin
      wide = val_x >> s1_q.shift;
      if (s1_q.sign) wide = -wide;
    end
  end

  always_comb begin
    hi    = s1_q.ovf ? !s1_q.sign : (wide > FIX_MAX);
    lo    = s1_q.ovf ?  s1_q.sign : (wide < FIX_MIN);
    sat_d = hi | lo | s1_q.nan;
    res_d = wide[FIX_W-1:0];
    if (s1_q.nan)  res_d = '0;
    else if (hi)   res_d = FIX_MAX[FIX_W-1:0];
    else if (lo)   res_d = FIX_MIN[FIX_W-1:0];
  end

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      s2_vld  <= 1'b0;
      s2_sat  <= 1'b0;
      s2_data <= '0;
    end else begin
      s2_vld  <= s1_q.valid;
      s2_sat  <= s1_q.valid && sat_d;
      s2_data <= res_d;
    end
  end

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n)            sat_flag <= 1'b0;
    else if (conf_en)          sat_flag <= 1'b0;
    else if (s2_vld && s2_sat) sat_flag <= 1'b1;
  end

`ifdef NPU_IN_SAT_COUNT_EN
  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n)                                        sat_count <= '0;
    else if (conf_en)                                      sat_count <= '0;
    else if (s2_vld && s2_sat && sat_count != 16'hFFFF)    sat_count <= sat_count + 16'd1;
  end
`endif

  npu_sync_fifo #(.W(FIX_W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .rst_n (npu_rst_n),
    .push  (s2_vld),
    .wdata (s2_data),
    .pop   (out_ready),
    .rdata (out_data),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;

  a_no_write_when_full: assert property (@(posedge CLK) disable iff (!npu_rst_n) !(s2_vld && full));

endmodule

// File: tb/tb_npu_input_convert_fifo.sv
// Directed bench for npu_input_convert_fifo: conversion vectors, latency,
// credit back-pressure, same-edge config and async reset.
module tb_npu_input_convert_fifo;

  logic        CLK = 1'b0;
  logic        npu_rst_n;
  logic        in_valid, in_ready;
  logic [32:0] in_data;
  logic        conf_en;
  logic [15:0] conf_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [4:0]  fifo_level;
  logic        full, empty, sat_flag;
`ifdef NPU_IN_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  npu_input_convert_fifo dut (
    .CLK        (CLK),
    .npu_rst_n  (npu_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .conf_en    (conf_en),
    .conf_data  (conf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .full       (full),
    .empty      (empty),
`ifdef NPU_IN_SAT_COUNT_EN
    .sat_count  (sat_count),
`endif
    .sat_flag   (sat_flag)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic conf(input logic mode, input int s);
    conf_data     = '0;
    conf_data[15] = mode;
    conf_data[5:0] = s[5:0];
    conf_en = 1'b1;
    tick();
    conf_en = 1'b0;
  endtask

  task automatic send(input logic [32:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic head(input string tag, input logic [15:0] exp);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  sent, popped;
    logic acc, pp;
    npu_rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    conf_en = 1'b0; conf_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", fifo_level, 0);
    npu_rst_n = 1'b1;
    tick();

    // latency: visible after accept edge + 2
    conf(1'b0, 7);
    send(33'h0_0000_1234);
    chk("lat_n0", out_valid, 0);
    tick();
    chk("lat_n1", out_valid, 0);
    tick();
    chk("lat_n2", out_valid, 1);
    head("int_s7", 16'h1234);
    chk("pop_to_empty", empty, 1);

    // int left-shift saturation
    conf(1'b0, 0);
    chk("sat_clr_conf", sat_flag, 0);
    send(33'h0_0000_0200);
    send(33'h1_FFFF_FE00);
    tick(); tick();
    chk("sat_flag_set", sat_flag, 1);
    head("int_sat_hi", 16'h7FFF);
    head("int_sat_lo", 16'h8000);

    // exact bounds, no saturation
    conf(1'b0, 0);
    send(33'h0_0000_00FF);
    send(33'h1_FFFF_FF00);
    tick(); tick();
    head("int_edge_hi", 16'h7F80);
    head("int_edge_lo", 16'h8000);
    chk("edge_no_sat", sat_flag, 0);

    // right shifts: floor, and shift past the input width
    conf(1'b0, 10);
    send(33'h1_FFFF_FFF9);
    send(33'h0_0000_000F);
    tick(); tick();
    head("int_rsh_neg", 16'hFFFF);
    head("int_rsh_pos", 16'h0001);
    conf(1'b0, 63);
    send(33'h0_FFFF_FFFF);
    send(33'h1_0000_0000);
    tick(); tick();
    head("int_rsh_big_pos", 16'h0000);
    head("int_rsh_big_neg", 16'hFFFF);

    // float, S=0
    conf(1'b1, 0);
    send(33'h0_C380_0000);
    send(33'h0_BBC0_0000);
    send(33'h0_3FC0_0000);
    send(33'h0_BF80_0000);
    send(33'h0_0000_0001);
    tick(); tick();
    head("fp_m256", 16'h8000);
    head("fp_trunc0", 16'h0000);
    head("fp_1p5", 16'h00C0);
    head("fp_m1", 16'hFF80);
    head("fp_denorm", 16'h0000);
    chk("fp_no_sat", sat_flag, 0);
    send(33'h0_7F80_0000);
    send(33'h0_FF80_0000);
    tick(); tick();
    head("fp_pinf", 16'h7FFF);
    head("fp_ninf", 16'h8000);
    chk("fp_inf_sat", sat_flag, 1);
    conf(1'b1, 0);
    chk("fp_sat_clr", sat_flag, 0);
    send(33'h0_7FC0_0000);
    tick(); tick();
    head("fp_nan", 16'h0000);
    chk("fp_nan_sat", sat_flag, 1);
    conf(1'b1, 63);
    send(33'h0_3F80_0000);
    tick(); tick();
    head("fp_exp_ovf", 16'h7FFF);

    // config write on the accept edge applies to the following sample only
    conf(1'b0, 7);
    in_valid = 1'b1; in_data = 33'h0_0000_0010;
    conf_en = 1'b1; conf_data = 16'h8001;
    tick();
    conf_en = 1'b0; in_data = 33'h0_3FC0_0000;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    head("cfg_same_edge", 16'h0010);
    head("cfg_next_fp", 16'h0180);

    // back-pressure: 20 offered, consumer stalled, then drained in order
    conf(1'b0, 7);
    sent = 0; popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 20; cyc++) begin
      out_ready = (cyc >= 25);
      in_valid  = (sent < 20);
      in_data   = 33'h100 + 33'(sent);
      if (cyc == 24) begin
        chk("bp_accepted", sent, 16);
        chk("bp_full", full, 1);
        chk("bp_level", fifo_level, 16);
        chk("bp_in_ready", in_ready, 0);
      end
      acc = in_valid && in_ready;
      pp  = out_ready && out_valid;
      if (pp) chk("bp_order", out_data, 32'h100 + 32'(popped));
      tick();
      if (acc) sent++;
      if (pp)  popped++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_drained", popped, 20);
    chk("bp_empty", empty, 1);

    // async reset with level 5 and two samples in flight
    conf(1'b0, 0);
    send(33'h0_0000_0200);
    for (int i = 1; i < 7; i++) send(33'(i));
    chk("mid_level", fifo_level, 5);
    chk("mid_sat", sat_flag, 1);
    #3;
    npu_rst_n = 1'b0;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sat", sat_flag, 0);
    chk("arst_out_valid", out_valid, 0);
    tick();
    npu_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
